// File: rtl/vga_txt_pkg.sv
// Shared constants and state encoding for the 80x30 text video buffer write side.
// Holds screen geometry defaults, terminal control codes and the write-controller states.
package vga_txt_pkg;

  localparam int          COLS_DEF      = 80;
  localparam int          ROWS_DEF      = 30;
  localparam logic [7:0]  FILL_CHAR_DEF = 8'h20;

  localparam logic [7:0]  CC_BS = 8'h08;
  localparam logic [7:0]  CC_LF = 8'h0A;
  localparam logic [7:0]  CC_FF = 8'h0C;
  localparam logic [7:0]  CC_CR = 8'h0D;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLR_LINE = 2'd1,
    CLR_SCR  = 2'd2
  } state_t;

endpackage

// File: rtl/vga_vbuf_fill.sv
// Fill engine: walks len consecutive addresses from base, one strobe per cycle.
// The first strobe is presented in the start cycle; done pulses the cycle after the last one.
module vga_vbuf_fill #(
  parameter int AW = 11
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  output logic          we,
  output logic [AW-1:0] addr,
  output logic          done
);

  typedef logic [AW-1:0] addr_t;
  typedef logic [AW:0]   len_t;

  localparam addr_t ONE_A = addr_t'(1);
  localparam len_t  ONE_L = len_t'(1);

  logic  active_q;
  addr_t ptr_q;
  len_t  rem_q;
  logic  last;

  assign we   = start | active_q;
  assign addr = start ? base : ptr_q;
  assign last = start ? (len == ONE_L) : (active_q && (rem_q == ONE_L));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      active_q <= 1'b0;
      ptr_q    <= '0;
      rem_q    <= '0;
      done     <= 1'b0;
    end else begin
      done <= last;
      if (start) begin
        ptr_q    <= base + ONE_A;
        rem_q    <= len - ONE_L;
        active_q <= (len > ONE_L);
      end else if (active_q) begin
        ptr_q <= ptr_q + ONE_A;
        rem_q <= rem_q - ONE_L;
        if (rem_q == ONE_L) active_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/vga_vbuf_wr_ctrl.sv
// Host write sequencer for the text video buffer: decodes terminal bytes, tracks the cursor
// and time-shares the single buffer write port with the line/screen fill engine.
module vga_vbuf_wr_ctrl
  import vga_txt_pkg::*;
#(
  parameter int         COLS      = COLS_DEF,
  parameter int         ROWS      = ROWS_DEF,
  parameter int         AW        = 11,
  parameter logic [7:0] FILL_CHAR = FILL_CHAR_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [7:0]    i_d,
  input  logic          i_valid,
  output logic          o_ready,
  output logic [7:0]    o_d_we,
  output logic [AW-1:0] o_addr_we,
  output logic          o_we_en_h,
  output logic [6:0]    o_cur_x,
  output logic [4:0]    o_cur_y,
  output logic          o_busy
);

  typedef logic [AW-1:0] addr_t;
  typedef logic [AW:0]   len_t;

  localparam logic [6:0] X_LAST   = 7'(COLS - 1);
  localparam logic [4:0] Y_LAST   = 5'(ROWS - 1);
  localparam addr_t      COLS_A   = addr_t'(COLS);
  localparam len_t       LEN_LINE = len_t'(COLS);
  localparam len_t       LEN_SCR  = len_t'(COLS * ROWS);

  state_t     state_q, state_d;
  logic       started_q, started_d;
  logic       line_pend_q, line_pend_d;
  logic [6:0] cur_x_q, cur_x_d;
  logic [4:0] cur_y_q, cur_y_d;
  addr_t      row_base_q, row_base_d;
  logic       ready_q, busy_q;
  logic       we_q;
  addr_t      addr_q;
  logic [7:0] d_q;

  logic       accept;
  logic [4:0] adv_y;
  addr_t      adv_rb;
  logic       wr_we;
  addr_t      wr_addr;
  logic       fill_start;
  addr_t      fill_base;
  len_t       fill_len;
  logic       fill_we;
  addr_t      fill_addr;
  logic       fill_done;

  vga_vbuf_fill #(.AW(AW)) u_fill (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .start   (fill_start),
    .base    (fill_base),
    .len     (fill_len),
    .we      (fill_we),
    .addr    (fill_addr),
    .done    (fill_done)
  );

  assign accept  = i_valid && ready_q;
  assign wr_addr = row_base_q + addr_t'(cur_x_q);

  // Next row with wrap to the top; the screen never scrolls.
  always_comb begin
    adv_y  = cur_y_q + 5'd1;
    adv_rb = row_base_q + COLS_A;
    if (cur_y_q == Y_LAST) begin
      adv_y  = '0;
      adv_rb = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    started_d   = started_q;
    line_pend_d = line_pend_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    row_base_d  = row_base_q;
    wr_we       = 1'b0;
    fill_start  = 1'b0;
    fill_base   = '0;
    fill_len    = LEN_LINE;
    case (state_q)
      IDLE: begin
        if (!started_q) begin
          started_d  = 1'b1;
          state_d    = CLR_SCR;
          fill_start = 1'b1;
          fill_len   = LEN_SCR;
        end else if (accept) begin
          if (i_d >= 8'h20) begin
            wr_we = 1'b1;
            if (cur_x_q == X_LAST) begin
              // The line clear waits one cycle so it follows the character write back to back.
              cur_x_d     = '0;
              cur_y_d     = adv_y;
              row_base_d  = adv_rb;
              line_pend_d = 1'b1;
              state_d     = CLR_LINE;
            end else begin
              cur_x_d = cur_x_q + 7'd1;
            end
          end else begin
            case (i_d)
              CC_CR: cur_x_d = '0;
              CC_LF: begin
                cur_y_d    = adv_y;
                row_base_d = adv_rb;
                state_d    = CLR_LINE;
                fill_start = 1'b1;
                fill_base  = adv_rb;
                fill_len   = LEN_LINE;
              end
              CC_BS: if (cur_x_q != 7'd0) cur_x_d = cur_x_q - 7'd1;
              CC_FF: begin
                state_d    = CLR_SCR;
                fill_start = 1'b1;
                fill_len   = LEN_SCR;
              end
              default: ;
            endcase
          end
        end
      end
      CLR_LINE: begin
        if (line_pend_q) begin
          line_pend_d = 1'b0;
          fill_start  = 1'b1;
          fill_base   = row_base_q;
          fill_len    = LEN_LINE;
        end else if (fill_done) begin
          state_d = IDLE;
        end
      end
      CLR_SCR: begin
        if (fill_done) begin
          state_d    = IDLE;
          cur_x_d    = '0;
          cur_y_d    = '0;
          row_base_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      started_q   <= 1'b0;
      line_pend_q <= 1'b0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      row_base_q  <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      d_q         <= '0;
    end else begin
      state_q     <= state_d;
      started_q   <= started_d;
      line_pend_q <= line_pend_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      row_base_q  <= row_base_d;
      ready_q     <= (state_d == IDLE) && started_d;
      busy_q      <= (state_d != IDLE);
      // Host writes and fill strobes never coincide, so one output register serves both.
      we_q        <= wr_we | fill_we;
      addr_q      <= wr_we ? wr_addr : fill_addr;
      d_q         <= wr_we ? i_d : FILL_CHAR;
    end
  end

  assign o_ready   = ready_q;
  assign o_busy    = busy_q;
  assign o_we_en_h = we_q;
  assign o_addr_we = addr_q;
  assign o_d_we    = d_q;
  assign o_cur_x   = cur_x_q;
  assign o_cur_y   = cur_y_q;

endmodule

// File: tb/tb_vga_vbuf_wr_ctrl.sv
// Scoreboard bench for vga_vbuf_wr_ctrl: a terminal-level model queues expected buffer writes,
// a monitor pops them on every strobe.
module tb_vga_vbuf_wr_ctrl;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int AW    = 12;
  localparam int TOTAL = COLS * ROWS;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [7:0]    i_d;
  logic          i_valid;
  logic          o_ready;
  logic [7:0]    o_d_we;
  logic [AW-1:0] o_addr_we;
  logic          o_we_en_h;
  logic [6:0]    o_cur_x;
  logic [4:0]    o_cur_y;
  logic          o_busy;

  vga_vbuf_wr_ctrl #(.COLS(COLS), .ROWS(ROWS), .AW(AW), .FILL_CHAR(8'h20)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_d       (i_d),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_d_we    (o_d_we),
    .o_addr_we (o_addr_we),
    .o_we_en_h (o_we_en_h),
    .o_cur_x   (o_cur_x),
    .o_cur_y   (o_cur_y),
    .o_busy    (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_checks = 0;
  int  n_errors = 0;
  int  mx = 0;
  int  my = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_wr(input int addr, input int data);
    wr_t w;
    w.a = AW'(addr);
    w.d = 8'(data);
    exp_q.push_back(w);
  endfunction

  function automatic void push_fill(input int base, input int n);
    for (int i = 0; i < n; i++) push_wr(base + i, 8'h20);
  endfunction

  // Terminal behaviour: returns how many cycles o_ready should stay low after the byte.
  function automatic int model(input logic [7:0] b);
    if (b >= 8'h20) begin
      push_wr(my * COLS + mx, b);
      if (mx == COLS - 1) begin
        mx = 0;
        my = (my + 1) % ROWS;
        push_fill(my * COLS, COLS);
        return COLS + 1;
      end
      mx++;
      return 0;
    end
    case (b)
      8'h0D: mx = 0;
      8'h0A: begin
        my = (my + 1) % ROWS;
        push_fill(my * COLS, COLS);
        return COLS;
      end
      8'h08: if (mx > 0) mx--;
      8'h0C: begin
        push_fill(0, TOTAL);
        mx = 0;
        my = 0;
        return TOTAL;
      end
      default: ;
    endcase
    return 0;
  endfunction

  always @(negedge i_clk) begin
    if (i_rst_n && o_we_en_h) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe_addr", int'(o_addr_we), -1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", int'(o_addr_we), int'(mon_e.a));
        chk("wr_data", int'(o_d_we), int'(mon_e.d));
      end
    end
  end

  task automatic check_cursor(input string tag);
    chk({tag, "_cur_x"}, int'(o_cur_x), mx);
    chk({tag, "_cur_y"}, int'(o_cur_y), my);
    chk({tag, "_busy"}, int'(o_busy), 0);
  endtask

  task automatic wait_ready(input string tag);
    int guard;
    guard = 0;
    while (!o_ready && guard < 6000) begin
      @(negedge i_clk);
      guard++;
    end
    if (!o_ready) chk({tag, "_ready_timeout"}, 0, 1);
  endtask

  // keep=1 leaves i_valid asserted and returns right after the transfer edge.
  task automatic send(input logic [7:0] b, input bit keep);
    int exp_low;
    int low;
    @(negedge i_clk);
    i_d     = b;
    i_valid = 1'b1;
    wait_ready("send");
    if (!o_ready) return;
    exp_low = model(b);
    @(posedge i_clk);
    #1;
    if (keep) return;
    i_valid = 1'b0;
    @(negedge i_clk);
    low = 0;
    while (!o_ready && low < 6000) begin
      low++;
      @(negedge i_clk);
    end
    chk("ready_low_cycles", low, exp_low);
    check_cursor("send");
  endtask

  initial begin
    int sel;
    int guard;
    logic [7:0] b;
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_d     = 8'h00;
    repeat (3) @(negedge i_clk);
    chk("rst_ready", int'(o_ready), 0);
    chk("rst_we", int'(o_we_en_h), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_addr", int'(o_addr_we), 0);
    chk("rst_data", int'(o_d_we), 0);
    chk("rst_cur_x", int'(o_cur_x), 0);
    chk("rst_cur_y", int'(o_cur_y), 0);

    // Power-up clear
    push_fill(0, TOTAL);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("powerup_busy", int'(o_busy), 1);
    wait_ready("powerup");
    @(negedge i_clk);
    check_cursor("powerup");
    chk("powerup_queue_empty", exp_q.size(), 0);

    send(8'h41, 1'b0);
    send(8'h42, 1'b0);
    send(8'h08, 1'b0);

    // Cursor to (5,3), then LF and CR
    send(8'h0D, 1'b0);
    repeat (3) send(8'h0A, 1'b0);
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i), 1'b0);
    send(8'h0A, 1'b0);
    send(8'h0D, 1'b0);

    // Cursor to (79,29), then a wrapping character
    send(8'h0C, 1'b0);
    repeat (29) send(8'h0A, 1'b0);
    for (int i = 0; i < COLS - 1; i++) send(8'h30 + 8'(i % 10), 1'b0);
    send(8'h5A, 1'b0);

    // FF at (10,10) with the next byte already waiting
    repeat (10) send(8'h0A, 1'b0);
    repeat (10) send(8'h2E, 1'b0);
    send(8'h0C, 1'b1);
    send(8'h51, 1'b0);

    for (int n = 0; n < 80; n++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 60)      b = 8'($urandom_range(32, 255));
      else if (sel < 70) b = 8'h0D;
      else if (sel < 80) b = 8'h0A;
      else if (sel < 90) b = 8'h08;
      else if (sel < 98) begin
        b = 8'($urandom_range(0, 31));
        if (b == 8'h0C || b == 8'h0A) b = 8'h01;
      end else b = 8'h0C;
      send(b, 1'b0);
    end

    // Reset in the middle of a screen clear
    send(8'h0C, 1'b1);
    i_valid = 1'b0;
    guard = 0;
    do begin
      @(negedge i_clk);
      guard++;
    end while (!(o_we_en_h && o_addr_we == AW'(1000)) && guard < 3000);
    chk("midfill_reached_1000", int'(o_addr_we), 1000);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("midfill_rst_we", int'(o_we_en_h), 0);
    chk("midfill_rst_ready", int'(o_ready), 0);
    chk("midfill_rst_busy", int'(o_busy), 0);
    exp_q.delete();
    mx = 0;
    my = 0;
    push_fill(0, TOTAL);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    wait_ready("restart");
    @(negedge i_clk);
    check_cursor("restart");

    send(8'h21, 1'b0);
    repeat (5) @(negedge i_clk);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
